spi_sensor_responder: RTL and testbench
=======================================

# spi_sensor_responder

SPI responder that models the PYTHON 1300 configuration port from the sensor side, so the sensor SPI controller can be exercised in simulation and in FPGA loopback without silicon. It oversamples SCK/SS_N/MOSI on the system clock, decodes 26-bit frames (9-bit address, R/W bit, 16-bit data), commits writes to an internal register file and shifts read data out on MISO. A host read port and a write-notify strobe expose the register contents to the rest of the design.

## Interface
- REG_DEPTH, 512: implemented registers, 1..512; addresses at or above this are unmapped.
- ERR_W, 8: width of the aborted-frame counter.
- clk  input  1  system clock; must be at least 8x the SCK frequency.
- reset_n  input  1  asynchronous, active-low reset.
- SCK  input  1  serial clock from the controller, asynchronous to clk.
- SS_N  input  1  active-low slave select.
- MOSI  input  1  serial data from the controller.
- MISO  output  1  serial data to the controller.
- host_addr  input  9  host read address.
- host_rdata  output  16  registered read data for host_addr.
- wr_strobe  output  1  one-cycle pulse when an SPI write commits.
- wr_addr  output  9  address of the last committed write.
- wr_data  output  16  data of the last committed write.
- busy  output  1  high while a frame is in progress (SS_N low, synchronized).
- err_count  output  ERR_W  saturating count of aborted frames.

## Operation
- Reset values: MISO 0, host_rdata 0, wr_strobe 0, wr_addr 0, wr_data 0, busy 0, err_count 0, all registers 0, state IDLE.
- Frame bit order, MSB first: bits 25..17 address, bit 16 R/W (1 = write, 0 = read), bits 15..0 data.
- The controller changes MOSI on falling SCK. The responder samples MOSI on each detected rising SCK edge and changes MISO on detected falling edges.
- States:
  - IDLE: wait for SS_N low, then clear the bit counter and go to ADDR.
  - ADDR: shift in 9 address bits. On the 10th rising edge, capture R/W and go to WR_DATA (R/W = 1) or RD_DATA (R/W = 0).
  - RD_DATA: latch reg[addr] into the output shift register on entry (0 if unmapped). Drive the MSB on the first falling edge after entry, then the next bit on each later falling edge, 16 bits total. Then go to DONE.
  - WR_DATA: shift in 16 bits. On the 16th bit, write reg[addr] if mapped, pulse wr_strobe and update wr_addr/wr_data, then go to DONE. Unmapped addresses produce no strobe and no write.
  - DONE: ignore further SCK edges; MISO 0; return to IDLE when SS_N goes high.
- Abort: SS_N rising in ADDR, RD_DATA or WR_DATA returns to IDLE with no write and no strobe, MISO 0, and err_count increments (saturating at the maximum).
- SCK edges while SS_N is high are ignored.
- Reset asserted mid-frame: immediate return to reset values. The next complete frame is decoded normally.
- Host port: host_rdata = reg[host_addr] one clk later (0 if unmapped). If an SPI write to the same address commits in the same cycle, the host port returns the old value.

## Timing
- Input path: SCK, SS_N and MOSI each go through 2-flop synchronizers, and edges are detected with one more flop. Edge-detect latency is 3 clk cycles from the pin.
- MISO updates 4 clk cycles after a falling SCK at the pin. This requires each SCK phase to be at least 4 clk cycles (SCK ≤ clk/8).
- wr_strobe asserts 4 clk cycles after the 26th rising SCK at the pin, for exactly 1 cycle.
- busy follows synchronized SS_N with 2 cycles of latency.

## Configuration
- SPI_RESP_ERR_COUNT_EN defined: the abort counter is built as described.
- SPI_RESP_ERR_COUNT_EN undefined: err_count is tied to 0, no counter logic is built, and abort behaviour is otherwise identical.

## Structure
- Shared package spi_pkg contains:
  - FRAME_BITS = 26, ADDR_BITS = 9, DATA_BITS = 16;
  - the responder state enum (IDLE, ADDR, RD_DATA, WR_DATA, DONE).
- Sub-module spi_sync_edge: 2-flop synchronizer plus rise/fall detector. Instantiated for SCK and SS_N. MOSI uses only the synchronizer path.
- Register file: inferred memory of REG_DEPTH x 16 with a combinational SPI read and a registered host read.

## Test plan
- Write frame addr 0x0A3, data 0x5A5A -> exactly one wr_strobe, wr_addr 0x0A3, wr_data 0x5A5A; host_addr 0x0A3 -> host_rdata 0x5A5A one cycle later.
- Read frame addr 0x0A3 after the write above -> MISO shifts 0x5A5A MSB first, and the controller's read data equals 0x5A5A.
- Read of never-written addr 0x1FF with REG_DEPTH = 256 -> MISO all zeros; a write to 0x1FF -> no wr_strobe.
- SS_N raised after 12 bits of a write to 0x010 -> no wr_strobe, reg[0x010] unchanged, err_count = 1 (0 without SPI_RESP_ERR_COUNT_EN); the next full frame succeeds.
- reset_n low during bit 5 of read data -> MISO 0 and busy 0 immediately; after release, a write of 0x1234 to 0x002 commits.
- 40 SCK toggles with SS_N high -> no state change, no strobe, MISO stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
// ============================================================================
// Module : spi_pkg
// Brief  : Frame geometry and responder state encoding for the PYTHON 1300
//          SPI configuration-port model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

  localparam int FRAME_BITS = 26;
  localparam int ADDR_BITS  = 9;
  localparam int DATA_BITS  = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    DONE    = 3'd4
  } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// Module : spi_sync_edge
// Brief  : Two-flop synchronizer with registered rise/fall pulses.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic dly_q;
  logic rise_q;
  logic fall_q;

  // Edge pulses are registered so they land three clocks after the pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      dly_q  <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
      rise_q <= sync_q & ~dly_q;
      fall_q <= ~sync_q & dly_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

`default_nettype wire

// File: rtl/spi_sensor_responder.sv
// ============================================================================
// Module : spi_sensor_responder
// Brief  : Sensor-side SPI responder with register file, host read port and
//          write notification. Define SPI_RESP_ERR_COUNT_EN to build the
//          aborted-frame counter; otherwise err_count is tied to zero.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sensor_responder
  import spi_pkg::*;
#(
  parameter int REG_DEPTH = 512,
  parameter int ERR_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 SCK,
  input  logic                 SS_N,
  input  logic                 MOSI,
  output logic                 MISO,
  input  logic [ADDR_BITS-1:0] host_addr,
  output logic [DATA_BITS-1:0] host_rdata,
  output logic                 wr_strobe,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 busy,
  output logic [ERR_W-1:0]     err_count
);

  localparam int IDX_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [ADDR_BITS:0] DEPTH_L     = (ADDR_BITS+1)'(REG_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_RW      = CNT_W'(ADDR_BITS);
  localparam logic [CNT_W-1:0]   CNT_WR_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]   CNT_RD_END  = CNT_W'(DATA_BITS);

  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_ss_level, w_ss_rise, w_ss_fall;
  logic w_unused;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (SCK),
    .sync_o  (w_sck_level),
    .rise_o  (w_sck_rise),
    .fall_o  (w_sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (SS_N),
    .sync_o  (w_ss_level),
    .rise_o  (w_ss_rise),
    .fall_o  (w_ss_fall)
  );

  assign w_unused = &{1'b0, w_sck_level, w_ss_fall};

  spi_state_e state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 miso_q, miso_d;
  logic                 strobe_q, strobe_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic                 mosi_meta_q, mosi_q;
  logic                 busy_pipe_q, busy_q;
  logic [DATA_BITS-1:0] host_rdata_q;
  logic [DATA_BITS-1:0] mem_q [REG_DEPTH];

  logic                 w_we;
  logic                 w_addr_mapped;
  logic                 w_host_mapped;
  logic [DATA_BITS-1:0] w_spi_rdata;
  logic [DATA_BITS-1:0] w_wr_word;

  assign w_addr_mapped = ({1'b0, addr_q} < DEPTH_L);
  assign w_host_mapped = ({1'b0, host_addr} < DEPTH_L);
  assign w_spi_rdata   = w_addr_mapped ? mem_q[addr_q[IDX_W-1:0]] : '0;
  assign w_wr_word     = {shift_q[DATA_BITS-2:0], mosi_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Abort (SS_N rising mid-frame) takes priority over any SCK edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!w_ss_level) state_d = ADDR;
      ADDR: begin
        if (w_ss_rise)                         state_d = IDLE;
        else if (w_sck_rise && cnt_q == CNT_RW) state_d = mosi_q ? WR_DATA : RD_DATA;
      end
      RD_DATA: begin
        if (w_ss_rise)                              state_d = IDLE;
        else if (w_sck_rise && cnt_q == CNT_RD_END) state_d = DONE;
      end
      WR_DATA: begin
        if (w_ss_rise)                               state_d = IDLE;
        else if (w_sck_rise && cnt_q == CNT_WR_LAST) state_d = DONE;
      end
      DONE:    if (w_ss_level) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    shift_d   = shift_q;
    miso_d    = miso_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    w_we      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        miso_d = 1'b0;
      end
      ADDR: begin
        if (w_ss_rise) begin
          miso_d = 1'b0;
        end else if (w_sck_rise) begin
          if (cnt_q == CNT_RW) begin
            cnt_d = '0;
            if (!mosi_q) shift_d = w_spi_rdata;
          end else begin
            addr_d = {addr_q[ADDR_BITS-2:0], mosi_q};
            cnt_d  = cnt_q + CNT_ONE;
          end
        end
      end
      RD_DATA: begin
        if (w_ss_rise) begin
          miso_d = 1'b0;
        end else if (w_sck_fall && cnt_q < CNT_RD_END) begin
          miso_d  = shift_q[DATA_BITS-1];
          shift_d = {shift_q[DATA_BITS-2:0], 1'b0};
          cnt_d   = cnt_q + CNT_ONE;
        end else if (w_sck_rise && cnt_q == CNT_RD_END) begin
          miso_d = 1'b0;
        end
      end
      WR_DATA: begin
        if (w_ss_rise) begin
          miso_d = 1'b0;
        end else if (w_sck_rise) begin
          shift_d = w_wr_word;
          cnt_d   = cnt_q + CNT_ONE;
          if (cnt_q == CNT_WR_LAST && w_addr_mapped) begin
            w_we      = 1'b1;
            strobe_d  = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = w_wr_word;
          end
        end
      end
      DONE:    miso_d = 1'b0;
      default: miso_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      addr_q      <= '0;
      shift_q     <= '0;
      miso_q      <= 1'b0;
      strobe_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      mosi_meta_q <= 1'b0;
      mosi_q      <= 1'b0;
      busy_pipe_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      shift_q     <= shift_d;
      miso_q      <= miso_d;
      strobe_q    <= strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      mosi_meta_q <= MOSI;
      mosi_q      <= mosi_meta_q;
      busy_pipe_q <= ~w_ss_level;
      busy_q      <= busy_pipe_q;
    end
  end

  // Host read samples the array before a same-cycle SPI write lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      host_rdata_q <= '0;
      for (int i = 0; i < REG_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      host_rdata_q <= w_host_mapped ? mem_q[host_addr[IDX_W-1:0]] : '0;
      if (w_we) mem_q[addr_q[IDX_W-1:0]] <= w_wr_word;
    end
  end

`ifdef SPI_RESP_ERR_COUNT_EN
  logic             w_abort;
  logic [ERR_W-1:0] err_q;

  assign w_abort = w_ss_rise &&
                   (state_q == ADDR || state_q == RD_DATA || state_q == WR_DATA);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_q <= '0;
    else if (w_abort && (err_q != {ERR_W{1'b1}}))
      err_q <= err_q + {{(ERR_W-1){1'b0}}, 1'b1};
  end

  assign err_count = err_q;
`else
  assign err_count = {ERR_W{1'b0}};
`endif

  assign MISO       = miso_q;
  assign host_rdata = host_rdata_q;
  assign wr_strobe  = strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_sensor_responder.sv
// ============================================================================
// Module : tb_spi_sensor_responder
// Brief  : Directed self-checking bench for spi_sensor_responder (REG_DEPTH 256).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_sensor_responder;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        SCK     = 1'b0;
  logic        SS_N    = 1'b1;
  logic        MOSI    = 1'b0;
  logic [8:0]  host_addr = 9'h000;
  logic        MISO;
  logic [15:0] host_rdata;
  logic        wr_strobe;
  logic [8:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic [7:0]  err_count;

  int checks      = 0;
  int failures    = 0;
  int strobe_cnt  = 0;
  int miso_hi_cnt = 0;

`ifdef SPI_RESP_ERR_COUNT_EN
  localparam logic [7:0] EXP_ERR_AFTER_ABORT = 8'd1;
`else
  localparam logic [7:0] EXP_ERR_AFTER_ABORT = 8'd0;
`endif

  spi_sensor_responder #(.REG_DEPTH(256), .ERR_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .SCK        (SCK),
    .SS_N       (SS_N),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) strobe_cnt++;
    if (MISO === 1'b1)      miso_hi_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One SCK half period: 8 system clocks.
  task automatic half();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic spi_frame(input logic [8:0] a, input logic rw, input logic [15:0] d,
                           input int nbits, input bit keep_ss, output logic [15:0] rx);
    logic [25:0] fr;
    logic [25:0] sh;
    fr   = {a, rw, d};
    sh   = '0;
    SS_N = 1'b0;
    half();
    for (int i = 0; i < nbits; i++) begin
      MOSI = fr[25-i];
      half();
      SCK = 1'b1;
      sh  = {sh[24:0], MISO};
      half();
      SCK = 1'b0;
    end
    half();
    if (!keep_ss) begin
      SS_N = 1'b1;
      MOSI = 1'b0;
      half();
    end
    rx = sh[15:0];
  endtask

  task automatic host_rd(input logic [8:0] a, output logic [15:0] v);
    host_addr = a;
    @(posedge clk);
    @(negedge clk);
    v = host_rdata;
  endtask

  initial begin
    logic [15:0] rx;
    logic [15:0] hv;
    int s0;
    int m0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_miso",   {31'b0, MISO},      32'h0);
    check("rst_hrdata", {16'b0, host_rdata}, 32'h0);
    check("rst_strobe", {31'b0, wr_strobe}, 32'h0);
    check("rst_waddr",  {23'b0, wr_addr},   32'h0);
    check("rst_wdata",  {16'b0, wr_data},   32'h0);
    check("rst_busy",   {31'b0, busy},      32'h0);
    check("rst_err",    {24'b0, err_count}, 32'h0);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Write 0x5A5A to 0x0A3
    s0 = strobe_cnt;
    spi_frame(9'h0A3, 1'b1, 16'h5A5A, 26, 1'b0, rx);
    check("wr1_strobes", strobe_cnt - s0, 32'd1);
    check("wr1_addr", {23'b0, wr_addr}, 32'h0A3);
    check("wr1_data", {16'b0, wr_data}, 32'h5A5A);
    host_rd(9'h0A3, hv);
    check("wr1_host", {16'b0, hv}, 32'h5A5A);

    // Read it back over SPI
    spi_frame(9'h0A3, 1'b0, 16'h0000, 26, 1'b0, rx);
    check("rd1_data", {16'b0, rx}, 32'h5A5A);
    check("rd1_miso_idle", {31'b0, MISO}, 32'h0);

    // Unmapped address 0x1FF
    m0 = miso_hi_cnt;
    spi_frame(9'h1FF, 1'b0, 16'h0000, 26, 1'b0, rx);
    check("rd_unmap_data", {16'b0, rx}, 32'h0);
    check("rd_unmap_miso_hi", miso_hi_cnt - m0, 32'd0);
    s0 = strobe_cnt;
    spi_frame(9'h1FF, 1'b1, 16'hFFFF, 26, 1'b0, rx);
    check("wr_unmap_strobes", strobe_cnt - s0, 32'd0);
    check("wr_unmap_waddr", {23'b0, wr_addr}, 32'h0A3);
    host_rd(9'h1FF, hv);
    check("wr_unmap_host", {16'b0, hv}, 32'h0);

    // Abort after 12 bits of a write
    s0 = strobe_cnt;
    spi_frame(9'h010, 1'b1, 16'h1111, 26, 1'b0, rx);
    check("pre_abort_strobes", strobe_cnt - s0, 32'd1);
    s0 = strobe_cnt;
    spi_frame(9'h010, 1'b1, 16'hBEEF, 12, 1'b0, rx);
    check("abort_strobes", strobe_cnt - s0, 32'd0);
    host_rd(9'h010, hv);
    check("abort_reg", {16'b0, hv}, 32'h1111);
    check("abort_err", {24'b0, err_count}, {24'b0, EXP_ERR_AFTER_ABORT});
    check("abort_waddr", {23'b0, wr_addr}, 32'h010);
    s0 = strobe_cnt;
    spi_frame(9'h010, 1'b1, 16'h2222, 26, 1'b0, rx);
    check("post_abort_strobes", strobe_cnt - s0, 32'd1);
    check("post_abort_wdata", {16'b0, wr_data}, 32'h2222);
    host_rd(9'h010, hv);
    check("post_abort_host", {16'b0, hv}, 32'h2222);

    // Reset in the middle of read data (MISO carries bit 11 = 1)
    spi_frame(9'h0A3, 1'b0, 16'h0000, 14, 1'b1, rx);
    check("midrd_miso", {31'b0, MISO}, 32'h1);
    check("midrd_busy", {31'b0, busy}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("midrst_miso", {31'b0, MISO}, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_waddr", {23'b0, wr_addr}, 32'h0);
    SS_N = 1'b1;
    SCK  = 1'b0;
    MOSI = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    s0 = strobe_cnt;
    spi_frame(9'h002, 1'b1, 16'h1234, 26, 1'b0, rx);
    check("postrst_strobes", strobe_cnt - s0, 32'd1);
    check("postrst_waddr", {23'b0, wr_addr}, 32'h002);
    check("postrst_wdata", {16'b0, wr_data}, 32'h1234);
    host_rd(9'h002, hv);
    check("postrst_host", {16'b0, hv}, 32'h1234);
    host_rd(9'h0A3, hv);
    check("postrst_cleared", {16'b0, hv}, 32'h0);

    // SCK activity with SS_N high
    s0 = strobe_cnt;
    m0 = miso_hi_cnt;
    for (int i = 0; i < 40; i++) begin
      MOSI = i[1];
      repeat (4) @(posedge clk);
      #1;
      SCK = ~SCK;
    end
    repeat (8) @(posedge clk);
    #1;
    check("ssh_strobes", strobe_cnt - s0, 32'd0);
    check("ssh_miso_hi", miso_hi_cnt - m0, 32'd0);
    check("ssh_busy", {31'b0, busy}, 32'h0);
    check("ssh_err", {24'b0, err_count}, 32'h0);
    spi_frame(9'h002, 1'b0, 16'h0000, 26, 1'b0, rx);
    check("ssh_readback", {16'b0, rx}, 32'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
